mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised successor to the single-cycle memory stage of the RISC-V pipeline; sits between EX and WB.
- Replaces the fixed-latency data port with a req/ack bus handshake that tolerates wait states.
- Adds XLEN 32/64, optional splitting of misaligned accesses into two aligned beats, and a bus-error/timeout fault path.
- EX is stalled through ex_ready_o while an access is outstanding.

Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64. NB = XLEN/8.
- SPLIT_MISALIGNED, 1: 1 = misaligned access becomes two beats; 0 = misaligned access faults with no bus request.
- TIMEOUT_CYCLES, 255: maximum cycles waiting for dack_i per beat before a fault; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; one clock, reset is asynchronous and active-high
- ex_valid_i  in  1  EX presents an instruction
- ex_ready_o  out  1  stage can accept
- ex_alu_res_i  in  XLEN  ALU result, also the effective address
- ex_mem_data_i  in  XLEN  store data
- ex_mem_rd_i  in  1  load
- ex_mem_wr_i  in  1  store; rd and wr both high is illegal
- ex_mem_signed_i  in  1  sign-extend load
- ex_mem_size_i  in  2  0=B, 1=H, 2=W, 3=D (D legal only when XLEN=64, else fault)
- ex_rd_index_i  in  5  destination register
- dreq_o  out  1  bus request
- dwr_o  out  1  write beat
- daddr_o  out  XLEN  NB-aligned beat address
- dwdata_o  out  XLEN  lane-positioned write data
- dbe_o  out  NB  byte enables
- dack_i  in  1  beat complete; drdata_i valid
- drdata_i  in  XLEN  read data
- derr_i  in  1  bus error, qualified by dack_i
- mem_valid_o  out  1  one-cycle result strobe to WB
- mem_rd_index_o  out  5  destination register
- mem_result_o  out  XLEN  load data or ALU result
- mem_fault_o  out  1  access fault, qualified by mem_valid_o
- mem_busy_o  out  1  an access is in flight (hazard unit)

Behaviour:
- Reset (asynchronous): state IDLE; dreq_o, dwr_o, mem_valid_o, mem_fault_o, mem_busy_o = 0; daddr_o, dwdata_o, dbe_o, mem_result_o, mem_rd_index_o = 0; timeout counter = 0.
- Reset asserted mid-access abandons the beat immediately. A later dack_i is ignored while in IDLE.
- States: IDLE, BEAT0, BEAT1.
- ex_ready_o = (state==IDLE). mem_busy_o = (state!=IDLE).
- IDLE, ex_valid_i with no rd/wr: next cycle mem_valid_o=1, mem_result_o=ex_alu_res_i, mem_fault_o=0 (1-cycle latency, no bus activity).
- IDLE, memory op: latch all inputs. Let off = addr mod NB, bytes = 1<<size.
  - Illegal size, or misaligned (off+bytes>NB) with SPLIT_MISALIGNED=0: next cycle mem_valid_o=1, mem_fault_o=1, mem_result_o=addr, no request.
  - Otherwise: go to BEAT0 with registered outputs.
- BEAT0:
  - dreq_o=1; daddr_o=addr with low log2(NB) bits cleared.
  - dbe_o = bytes from off up to min(off+bytes, NB)-1.
  - dwdata_o = data << 8*off.
  - dreq_o and all beat outputs stay stable until dack_i.
- BEAT0 + dack_i:
  - derr_i=1: fault, return to IDLE.
  - Else if split needed: go to BEAT1.
  - Else: complete.
- BEAT1:
  - daddr_o = beat0 address + NB.
  - dbe_o = low (off+bytes-NB) bytes.
  - dwdata_o = data >> 8*(NB-off).
- dack_i may arrive in the same cycle dreq_o first rises (zero wait states).
- Completion: mem_valid_o=1 for exactly one cycle after the final dack_i, with state IDLE in the same cycle. A new EX op may be accepted on that cycle.
- Load assembly:
  - raw = (beat0 data >> 8*off) | (beat1 data << 8*(NB-off)).
  - Truncate raw to the access size, then zero- or sign-extend to XLEN.
- Timeout: counter clears on each beat entry and increments while dreq_o && !dack_i. Reaching TIMEOUT_CYCLES gives a fault completion and drops dreq_o.
- Fault completion: mem_fault_o=1, mem_result_o = faulting beat address.
- Split store error on beat1: beat0 bytes remain written; fault reported anyway.
- dack_i outside BEAT0/BEAT1 is ignored.

Test Plan:
- Aligned LW, XLEN=32, addr 0x104, dack_i 3 cycles after dreq_o, drdata_i 0xDEADBEEF -> daddr_o=0x104, dbe_o=0xF; mem_result_o=0xDEADBEEF one cycle after ack; ex_ready_o low throughout.
- LB signed, addr 0x103, drdata_i 0x80AABBCC -> dbe_o=0x8, mem_result_o=0xFFFFFF80. Repeat unsigned -> 0x00000080.
- Split SW, addr 0x206, data 0x11223344 -> beat0 0x204/be 0xC/wdata 0x33440000; beat1 0x208/be 0x3/wdata 0x00001122; one mem_valid_o.
- Split LH, addr 0x7, beat data 0x44000000 then 0x00000055, signed -> mem_result_o=0x00005544. With SPLIT_MISALIGNED=0 -> fault, no dreq_o.
- TIMEOUT_CYCLES=4, no dack_i -> dreq_o drops after 4 cycles; mem_fault_o=1 with mem_result_o = beat address. derr_i on beat0 -> fault, no beat1.
- Reset asserted in BEAT0 -> outputs clear asynchronously; stale dack_i ignored; back-to-back ALU ops give mem_valid_o every cycle.

Source files
------------

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - memory stage with req/ack data bus, misaligned split and fault path
module mem_stage_hs #(
  parameter int XLEN             = 32,
  parameter int SPLIT_MISALIGNED = 1,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   ex_alu_res_i,
  input  logic [XLEN-1:0]   ex_mem_data_i,
  input  logic              ex_mem_rd_i,
  input  logic              ex_mem_wr_i,
  input  logic              ex_mem_signed_i,
  input  logic [1:0]        ex_mem_size_i,
  input  logic [4:0]        ex_rd_index_i,
  output logic              dreq_o,
  output logic              dwr_o,
  output logic [XLEN-1:0]   daddr_o,
  output logic [XLEN-1:0]   dwdata_o,
  output logic [XLEN/8-1:0] dbe_o,
  input  logic              dack_i,
  input  logic [XLEN-1:0]   drdata_i,
  input  logic              derr_i,
  output logic              mem_valid_o,
  output logic [4:0]        mem_rd_index_o,
  output logic [XLEN-1:0]   mem_result_o,
  output logic              mem_fault_o,
  output logic              mem_busy_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic              wr_q, wr_d;
  logic              signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic              split_q, split_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              dreq_q, dreq_d;
  logic              dwr_q, dwr_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [XLEN-1:0]   dwdata_q, dwdata_d;
  logic [NB-1:0]     dbe_q, dbe_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_fault_q, mem_fault_d;
  logic [XLEN-1:0]   mem_result_q, mem_result_d;
  logic [4:0]        mem_rd_index_q, mem_rd_index_d;

  // Byte-enable span across two consecutive beats: low half is beat0, high half beat1.
  function automatic logic [2*NB-1:0] be_span(input logic [OW-1:0] off, input logic [1:0] size);
    logic [2*NB-1:0] base;
    case (size)
      2'd0:    base = (2*NB)'(8'h01);
      2'd1:    base = (2*NB)'(8'h03);
      2'd2:    base = (2*NB)'(8'h0F);
      default: base = (2*NB)'(8'hFF);
    endcase
    return base << off;
  endfunction

  // Store data positioned on byte lanes across two beats.
  function automatic logic [2*XLEN-1:0] data_span(input logic [XLEN-1:0] data,
                                                  input logic [OW-1:0] off);
    return {{XLEN{1'b0}}, data} << {off, 3'b000};
  endfunction

  // True when the access runs past the end of its naturally aligned word.
  function automatic logic crosses(input logic [OW-1:0] off, input logic [1:0] size);
    return (5'(off) + (5'd1 << size)) > 5'(NB);
  endfunction

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:OW], {OW{1'b0}}};
  endfunction

  // Joins both beats, truncates to the access size and extends to XLEN.
  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] b0,
                                               input logic [XLEN-1:0] b1,
                                               input logic [OW-1:0]   off,
                                               input logic [1:0]      size,
                                               input logic            sgn);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] mask;
    logic            sbit;
    raw  = XLEN'({b1, b0} >> {off, 3'b000});
    mask = (XLEN'(1) << (7'd8 << size)) - XLEN'(1);
    case (size)
      2'd0:    sbit = raw[7];
      2'd1:    sbit = raw[15];
      2'd2:    sbit = raw[31];
      default: sbit = raw[XLEN-1];
    endcase
    return (raw & mask) | ({XLEN{sgn & sbit}} & ~mask);
  endfunction

  logic [2*NB-1:0]   be_in, be_lat;
  logic [2*XLEN-1:0] wd_in, wd_lat;
  logic              illegal_in, split_in, tmo_hit;

  assign be_in      = be_span(ex_alu_res_i[OW-1:0], ex_mem_size_i);
  assign wd_in      = data_span(ex_mem_data_i, ex_alu_res_i[OW-1:0]);
  assign be_lat     = be_span(addr_q[OW-1:0], size_q);
  assign wd_lat     = data_span(data_q, addr_q[OW-1:0]);
  assign split_in   = crosses(ex_alu_res_i[OW-1:0], ex_mem_size_i);
  // Simultaneous load and store is treated like an illegal size.
  assign illegal_in = ((ex_mem_size_i == 2'd3) && (XLEN == 32)) || (ex_mem_rd_i && ex_mem_wr_i);
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && ((tmo_q + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Next-state, bus beat and WB result computation.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    rdata0_d       = rdata0_q;
    wr_d           = wr_q;
    signed_d       = signed_q;
    size_d         = size_q;
    split_d        = split_q;
    tmo_d          = tmo_q;
    dreq_d         = dreq_q;
    dwr_d          = dwr_q;
    daddr_d        = daddr_q;
    dwdata_d       = dwdata_q;
    dbe_d          = dbe_q;
    mem_valid_d    = 1'b0;
    mem_fault_d    = 1'b0;
    mem_result_d   = mem_result_q;
    mem_rd_index_d = mem_rd_index_q;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          mem_rd_index_d = ex_rd_index_i;
          if (!ex_mem_rd_i && !ex_mem_wr_i) begin
            mem_valid_d  = 1'b1;
            mem_result_d = ex_alu_res_i;
          end else begin
            addr_d   = ex_alu_res_i;
            data_d   = ex_mem_data_i;
            wr_d     = ex_mem_wr_i;
            signed_d = ex_mem_signed_i;
            size_d   = ex_mem_size_i;
            split_d  = split_in;
            if (illegal_in || (split_in && (SPLIT_MISALIGNED == 0))) begin
              mem_valid_d  = 1'b1;
              mem_fault_d  = 1'b1;
              mem_result_d = ex_alu_res_i;
            end else begin
              state_d  = BEAT0;
              tmo_d    = 32'd0;
              dreq_d   = 1'b1;
              dwr_d    = ex_mem_wr_i;
              daddr_d  = align(ex_alu_res_i);
              dbe_d    = be_in[NB-1:0];
              dwdata_d = wd_in[XLEN-1:0];
            end
          end
        end
      end

      BEAT0, BEAT1: begin
        if (dack_i) begin
          if (derr_i) begin
            state_d      = IDLE;
            dreq_d       = 1'b0;
            dwr_d        = 1'b0;
            mem_valid_d  = 1'b1;
            mem_fault_d  = 1'b1;
            mem_result_d = daddr_q;
          end else if ((state_q == BEAT0) && split_q) begin
            state_d  = BEAT1;
            tmo_d    = 32'd0;
            rdata0_d = drdata_i;
            daddr_d  = daddr_q + XLEN'(NB);
            dbe_d    = be_lat[2*NB-1:NB];
            dwdata_d = wd_lat[2*XLEN-1:XLEN];
          end else begin
            state_d      = IDLE;
            dreq_d       = 1'b0;
            dwr_d        = 1'b0;
            mem_valid_d  = 1'b1;
            if (wr_q) begin
              mem_result_d = addr_q;
            end else if (state_q == BEAT1) begin
              mem_result_d = load_fmt(rdata0_q, drdata_i, addr_q[OW-1:0], size_q, signed_q);
            end else begin
              mem_result_d = load_fmt(drdata_i, '0, addr_q[OW-1:0], size_q, signed_q);
            end
          end
        end else if (tmo_hit) begin
          state_d      = IDLE;
          dreq_d       = 1'b0;
          dwr_d        = 1'b0;
          mem_valid_d  = 1'b1;
          mem_fault_d  = 1'b1;
          mem_result_d = daddr_q;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
        dreq_d  = 1'b0;
        dwr_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any beat in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      rdata0_q       <= '0;
      wr_q           <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'd0;
      split_q        <= 1'b0;
      tmo_q          <= 32'd0;
      dreq_q         <= 1'b0;
      dwr_q          <= 1'b0;
      daddr_q        <= '0;
      dwdata_q       <= '0;
      dbe_q          <= '0;
      mem_valid_q    <= 1'b0;
      mem_fault_q    <= 1'b0;
      mem_result_q   <= '0;
      mem_rd_index_q <= 5'd0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      rdata0_q       <= rdata0_d;
      wr_q           <= wr_d;
      signed_q       <= signed_d;
      size_q         <= size_d;
      split_q        <= split_d;
      tmo_q          <= tmo_d;
      dreq_q         <= dreq_d;
      dwr_q          <= dwr_d;
      daddr_q        <= daddr_d;
      dwdata_q       <= dwdata_d;
      dbe_q          <= dbe_d;
      mem_valid_q    <= mem_valid_d;
      mem_fault_q    <= mem_fault_d;
      mem_result_q   <= mem_result_d;
      mem_rd_index_q <= mem_rd_index_d;
    end
  end

  assign ex_ready_o     = (state_q == IDLE);
  assign mem_busy_o     = (state_q != IDLE);
  assign dreq_o         = dreq_q;
  assign dwr_o          = dwr_q;
  assign daddr_o        = daddr_q;
  assign dwdata_o       = dwdata_q;
  assign dbe_o          = dbe_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_fault_o    = mem_fault_q;
  assign mem_result_o   = mem_result_q;
  assign mem_rd_index_o = mem_rd_index_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - self-checking bench for mem_stage_hs
module tb_mem_stage_hs;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ex_valid_i, ns_valid_i;
  logic [31:0] ex_alu_res_i, ex_mem_data_i;
  logic        ex_mem_rd_i, ex_mem_wr_i, ex_mem_signed_i;
  logic [1:0]  ex_mem_size_i;
  logic [4:0]  ex_rd_index_i;
  logic        dack_i, derr_i;
  logic [31:0] drdata_i;

  logic        ex_ready_o, dreq_o, dwr_o, mem_valid_o, mem_fault_o, mem_busy_o;
  logic [31:0] daddr_o, dwdata_o, mem_result_o;
  logic [3:0]  dbe_o;
  logic [4:0]  mem_rd_index_o;

  logic        ns_ready, ns_dreq, ns_dwr, ns_vld, ns_fault, ns_busy;
  logic [31:0] ns_daddr, ns_dwdata, ns_res;
  logic [3:0]  ns_dbe;
  logic [4:0]  ns_rdi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rd, wr, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    int          nb, dly;
    logic [31:0] r0, r1;
    logic        e0, tmo;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1, res;
    logic        flt;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        flt;
    logic [4:0]  rdi;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mem_stage_hs #(.XLEN(32), .SPLIT_MISALIGNED(1), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_res_i(ex_alu_res_i), .ex_mem_data_i(ex_mem_data_i), .ex_mem_rd_i(ex_mem_rd_i),
    .ex_mem_wr_i(ex_mem_wr_i), .ex_mem_signed_i(ex_mem_signed_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_rd_index_i(ex_rd_index_i), .dreq_o(dreq_o), .dwr_o(dwr_o), .daddr_o(daddr_o),
    .dwdata_o(dwdata_o), .dbe_o(dbe_o), .dack_i(dack_i), .drdata_i(drdata_i), .derr_i(derr_i),
    .mem_valid_o(mem_valid_o), .mem_rd_index_o(mem_rd_index_o), .mem_result_o(mem_result_o),
    .mem_fault_o(mem_fault_o), .mem_busy_o(mem_busy_o)
  );

  mem_stage_hs #(.XLEN(32), .SPLIT_MISALIGNED(0), .TIMEOUT_CYCLES(4)) dut_ns (
    .clk_i(clk_i), .reset_i(reset_i), .ex_valid_i(ns_valid_i), .ex_ready_o(ns_ready),
    .ex_alu_res_i(ex_alu_res_i), .ex_mem_data_i(ex_mem_data_i), .ex_mem_rd_i(ex_mem_rd_i),
    .ex_mem_wr_i(ex_mem_wr_i), .ex_mem_signed_i(ex_mem_signed_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_rd_index_i(ex_rd_index_i), .dreq_o(ns_dreq), .dwr_o(ns_dwr), .daddr_o(ns_daddr),
    .dwdata_o(ns_dwdata), .dbe_o(ns_dbe), .dack_i(dack_i), .drdata_i(drdata_i), .derr_i(derr_i),
    .mem_valid_o(ns_vld), .mem_rd_index_o(ns_rdi), .mem_result_o(ns_res),
    .mem_fault_o(ns_fault), .mem_busy_o(ns_busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, sgn, input logic [1:0] sz,
                              input logic [31:0] addr, wdata, input int nb, dly,
                              input logic [31:0] r0, r1, input logic e0, tmo,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic [31:0] res, input logic flt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sgn = sgn; v.sz = sz; v.addr = addr; v.wdata = wdata;
    v.nb = nb; v.dly = dly; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.tmo = tmo;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.res = res; v.flt = flt;
    return v;
  endfunction

  // Result monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!reset_i && mem_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", mem_result_o, e.res);
        chk("fault", mem_fault_o, e.flt);
        chk("rd_index", mem_rd_index_o, e.rdi);
      end
    end
  end

  // Presents one op at the current falling edge and plays the bus slave.
  task automatic run_op(input vec_t v, input logic [4:0] rdi);
    exp_t e;
    chk("ready_at_issue", ex_ready_o, 1'b1);
    ex_valid_i = 1'b1; ex_alu_res_i = v.addr; ex_mem_data_i = v.wdata;
    ex_mem_rd_i = v.rd; ex_mem_wr_i = v.wr; ex_mem_signed_i = v.sgn;
    ex_mem_size_i = v.sz; ex_rd_index_i = rdi;
    e.res = v.res; e.flt = v.flt; e.rdi = rdi;
    sb.push_back(e);
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    if (v.nb == 0) begin
      chk("imm_no_req", dreq_o, 1'b0);
      chk("imm_valid", mem_valid_o, 1'b1);
      return;
    end
    for (int b = 0; b < v.nb; b++) begin
      chk("dreq", dreq_o, 1'b1);
      chk("daddr", daddr_o, (b == 0) ? v.a0 : v.a1);
      chk("dbe", dbe_o, (b == 0) ? v.be0 : v.be1);
      chk("dwdata", dwdata_o, (b == 0) ? v.wd0 : v.wd1);
      chk("dwr", dwr_o, v.wr);
      chk("ready_low", ex_ready_o, 1'b0);
      chk("busy", mem_busy_o, 1'b1);
      if (v.tmo) begin
        for (int w = 1; w < 4; w++) begin
          @(negedge clk_i);
          chk("tmo_dreq_hold", dreq_o, 1'b1);
        end
        @(negedge clk_i);
        chk("tmo_dreq_drop", dreq_o, 1'b0);
      end else begin
        for (int w = 0; w < v.dly; w++) begin
          @(negedge clk_i);
          chk("wait_dreq", dreq_o, 1'b1);
          chk("wait_daddr", daddr_o, (b == 0) ? v.a0 : v.a1);
          chk("wait_ready_low", ex_ready_o, 1'b0);
        end
        dack_i = 1'b1;
        drdata_i = (b == 0) ? v.r0 : v.r1;
        derr_i = (b == 0) ? v.e0 : 1'b0;
        @(negedge clk_i);
        dack_i = 1'b0; derr_i = 1'b0; drdata_i = 32'h0;
      end
    end
    chk("dreq_done", dreq_o, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           rd wr sg sz  addr          wdata          nb dly r0             r1             e0 to a0        be0   wd0            a1        be1   wd1            res            flt
    vecs.push_back(mk(0, 0, 0, 2, 32'h12345678, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,    4'h0, 32'h0,         32'h0,    4'h0, 32'h0,         32'h12345678, 0));
    vecs.push_back(mk(0, 0, 0, 2, 32'hCAFE0001, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,    4'h0, 32'h0,         32'h0,    4'h0, 32'h0,         32'hCAFE0001, 0));
    vecs.push_back(mk(0, 0, 0, 2, 32'h00000FFF, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,    4'h0, 32'h0,         32'h0,    4'h0, 32'h0,         32'h00000FFF, 0));
    vecs.push_back(mk(1, 0, 0, 2, 32'h104,      32'h0,         1, 3, 32'hDEADBEEF,  32'h0,         0, 0, 32'h104,  4'hF, 32'h0,         32'h0,    4'h0, 32'h0,         32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h103,      32'h0,         1, 1, 32'h80AABBCC,  32'h0,         0, 0, 32'h100,  4'h8, 32'h0,         32'h0,    4'h0, 32'h0,         32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h103,      32'h0,         1, 1, 32'h80AABBCC,  32'h0,         0, 0, 32'h100,  4'h8, 32'h0,         32'h0,    4'h0, 32'h0,         32'h00000080, 0));
    vecs.push_back(mk(0, 1, 0, 2, 32'h206,      32'h11223344,  2, 0, 32'h0,         32'h0,         0, 0, 32'h204,  4'hC, 32'h33440000,  32'h208,  4'h3, 32'h00001122,  32'h206,      0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h7,        32'h0,         2, 0, 32'h44000000,  32'h00000055,  0, 0, 32'h4,    4'h8, 32'h0,         32'h8,    4'h1, 32'h0,         32'h00005544, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h10A,      32'h0000ABCD,  1, 2, 32'h0,         32'h0,         0, 0, 32'h108,  4'hC, 32'hABCD0000,  32'h0,    4'h0, 32'h0,         32'h10A,      0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h102,      32'h0,         1, 0, 32'h87650000,  32'h0,         0, 0, 32'h100,  4'hC, 32'h0,         32'h0,    4'h0, 32'h0,         32'h00008765, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h102,      32'h0,         1, 0, 32'h87650000,  32'h0,         0, 0, 32'h100,  4'hC, 32'h0,         32'h0,    4'h0, 32'h0,         32'hFFFF8765, 0));
    vecs.push_back(mk(1, 0, 0, 3, 32'h40,       32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,    4'h0, 32'h0,         32'h0,    4'h0, 32'h0,         32'h40,       1));
    vecs.push_back(mk(1, 0, 0, 2, 32'h300,      32'h0,         1, 1, 32'h0,         32'h0,         1, 0, 32'h300,  4'hF, 32'h0,         32'h0,    4'h0, 32'h0,         32'h300,      1));
    vecs.push_back(mk(1, 0, 0, 2, 32'h404,      32'h0,         1, 0, 32'h0,         32'h0,         0, 1, 32'h404,  4'hF, 32'h0,         32'h0,    4'h0, 32'h0,         32'h404,      1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h101,      32'h0,         1, 0, 32'h0000F000,  32'h0,         0, 0, 32'h100,  4'h2, 32'h0,         32'h0,    4'h0, 32'h0,         32'h000000F0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 32'h10D,      32'h0,         2, 3, 32'hAABBCCDD,  32'h11223344,  0, 0, 32'h10C,  4'hE, 32'h0,         32'h110,  4'h1, 32'h0,         32'h44AABBCC, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h205,      32'hFFFFFF5A,  1, 1, 32'h0,         32'h0,         0, 0, 32'h204,  4'h2, 32'hFFFF5A00,  32'h0,    4'h0, 32'h0,         32'h205,      0));

    reset_i = 1'b1; ex_valid_i = 1'b0; ns_valid_i = 1'b0;
    ex_alu_res_i = 32'h0; ex_mem_data_i = 32'h0; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0;
    ex_mem_signed_i = 1'b0; ex_mem_size_i = 2'd0; ex_rd_index_i = 5'd0;
    dack_i = 1'b0; derr_i = 1'b0; drdata_i = 32'h0;

    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_dreq", dreq_o, 1'b0);
    chk("rst_dwr", dwr_o, 1'b0);
    chk("rst_daddr", daddr_o, 32'h0);
    chk("rst_dwdata", dwdata_o, 32'h0);
    chk("rst_dbe", dbe_o, 4'h0);
    chk("rst_valid", mem_valid_o, 1'b0);
    chk("rst_fault", mem_fault_o, 1'b0);
    chk("rst_result", mem_result_o, 32'h0);
    chk("rst_rdi", mem_rd_index_o, 5'd0);
    chk("rst_busy", mem_busy_o, 1'b0);
    chk("rst_ready", ex_ready_o, 1'b1);
    reset_i = 1'b0;
    @(negedge clk_i);

    foreach (vecs[i]) run_op(vecs[i], 5'(i + 1));

    // Misaligned access with splitting disabled faults without touching the bus.
    @(negedge clk_i);
    ns_valid_i = 1'b1; ex_alu_res_i = 32'h7; ex_mem_rd_i = 1'b1; ex_mem_wr_i = 1'b0;
    ex_mem_signed_i = 1'b1; ex_mem_size_i = 2'd1; ex_rd_index_i = 5'd9;
    @(negedge clk_i);
    ns_valid_i = 1'b0;
    chk("ns_valid", ns_vld, 1'b1);
    chk("ns_fault", ns_fault, 1'b1);
    chk("ns_result", ns_res, 32'h7);
    chk("ns_rdi", ns_rdi, 5'd9);
    chk("ns_no_req", ns_dreq, 1'b0);
    chk("ns_busy", ns_busy, 1'b0);
    @(negedge clk_i);
    chk("ns_valid_one", ns_vld, 1'b0);
    chk("ns_no_req2", ns_dreq, 1'b0);

    // Reset in BEAT0 clears outputs at once; a late ack must be ignored.
    ex_valid_i = 1'b1; ex_alu_res_i = 32'h500; ex_mem_rd_i = 1'b1; ex_mem_wr_i = 1'b0;
    ex_mem_signed_i = 1'b0; ex_mem_size_i = 2'd2; ex_rd_index_i = 5'd4;
    @(negedge clk_i);
    ex_valid_i = 1'b0;
    chk("pre_rst_dreq", dreq_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_dreq", dreq_o, 1'b0);
    chk("async_rst_daddr", daddr_o, 32'h0);
    chk("async_rst_dbe", dbe_o, 4'h0);
    chk("async_rst_busy", mem_busy_o, 1'b0);
    chk("async_rst_ready", ex_ready_o, 1'b1);
    @(negedge clk_i);
    reset_i = 1'b0;
    dack_i = 1'b1; drdata_i = 32'h12345678;
    @(negedge clk_i);
    dack_i = 1'b0; drdata_i = 32'h0;
    chk("stale_ack_dreq", dreq_o, 1'b0);
    chk("stale_ack_valid", mem_valid_o, 1'b0);
    chk("stale_ack_busy", mem_busy_o, 1'b0);

    // Back-to-back ALU ops after reset produce a strobe every cycle.
    for (int k = 0; k < 4; k++) begin
      vec_t v;
      v = mk(0, 0, 0, 2, 32'hA0 + 32'(k), 32'h0, 0, 0, 32'h0, 32'h0, 0, 0,
             32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'hA0 + 32'(k), 0);
      run_op(v, 5'(20 + k));
    end

    @(negedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
